// File: rtl/ripple_cnt_pkg.sv
// Shared types for the ripple counter: FSM states, count direction and slice operating modes.
package ripple_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ADD    = 2'd0,
        SUB    = 2'd1,
        A_GE_B = 2'd2
    } slice_mode_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/ripple_slice2.sv
// 2-bit add/subtract/compare slice; FCI/FCO chain between neighbouring slices.
module ripple_slice2
    import ripple_cnt_pkg::*;
(
    input  logic [1:0]  A,
    input  logic [1:0]  B,
    input  logic        FCI,
    input  slice_mode_e MODE,
    output logic [1:0]  F,
    output logic        FCO
);

    logic [1:0] b_eff;
    logic [2:0] sum;

    // SUB and A_GE_B both form A + ~B + FCI; FCI is the active-low borrow-in,
    // and a set FCO out of the top slice means A >= B.
    always_comb begin
        b_eff = (MODE == ADD) ? B : ~B;
        sum   = {1'b0, A} + {1'b0, b_eff} + {2'b00, FCI};
        F     = (MODE == A_GE_B) ? 2'b00 : sum[1:0];
        FCO   = sum[2];
    end

endmodule

// File: rtl/ripple_cnt_ctl.sv
// Loadable up/down counter on a 2-bit slice chain with load handshake, TC/GE flags and one-shot FSM.
// Define RIPPLE_CNT_SAT_EN to make free-running (ONESHOT=0) counting saturate at the terminal value.
module ripple_cnt_ctl
    import ripple_cnt_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               ONESHOT = 0,
    parameter logic [WIDTH-1:0] TC_UP   = '1,
    parameter logic [WIDTH-1:0] TC_DN   = '0
) (
    input  logic             CLK,
    input  logic             LSR,
    input  logic             CE,
    input  logic             LD_VLD,
    output logic             LD_RDY,
    input  logic [WIDTH-1:0] LDATA,
    input  logic             UPDN,
    input  logic [WIDTH-1:0] CMPV,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             GE,
    output logic             BUSY
);

    localparam int NS  = WIDTH / 2;
    localparam bit ONE = (ONESHOT != 0);

    state_e           state_q;
    logic [WIDTH-1:0] q_q;
    logic             dir_q;
    logic             tc_q;
    logic             ge_q;

    logic [WIDTH-1:0] cnt_d;
    logic             ge_d;
    logic [NS:0]      cnt_c;
    logic [NS:0]      cmp_c;
    logic [WIDTH-1:0] cmp_f;
    slice_mode_e      cnt_mode;
    logic [WIDTH-1:0] term;
    logic             at_term;
    logic             cnt_hit;
    logic             sat_hold;
    logic             unused_bits;

    always_comb begin
        cnt_mode = (dir_q == DIR_UP) ? ADD : SUB;
        term     = (dir_q == DIR_UP) ? TC_UP : TC_DN;
    end

    // Up: add 0 with carry-in 1. Down: add ~0 with borrow-in asserted (FCI=0).
    assign cnt_c[0] = (dir_q == DIR_UP);
    assign cmp_c[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < NS; g++) begin : g_slice
            ripple_slice2 u_cnt (
                .A    (q_q[2*g +: 2]),
                .B    (2'b00),
                .FCI  (cnt_c[g]),
                .MODE (cnt_mode),
                .F    (cnt_d[2*g +: 2]),
                .FCO  (cnt_c[g+1])
            );
            ripple_slice2 u_cmp (
                .A    (q_q[2*g +: 2]),
                .B    (CMPV[2*g +: 2]),
                .FCI  (cmp_c[g]),
                .MODE (A_GE_B),
                .F    (cmp_f[2*g +: 2]),
                .FCO  (cmp_c[g+1])
            );
        end
    endgenerate

    assign ge_d        = cmp_c[NS];
    assign unused_bits = ^{cnt_c[NS], cmp_f};
    assign at_term     = (q_q == term);
    assign cnt_hit     = (cnt_d == term);

`ifdef RIPPLE_CNT_SAT_EN
    assign sat_hold = !ONE && at_term;
`else
    assign sat_hold = 1'b0;
`endif

    // A load presented in RUN still wins over a pending count; LD_RDY only
    // advertises that no count would be competing with it.
    always_ff @(posedge CLK or posedge LSR) begin
        if (LSR) begin
            state_q <= IDLE;
            q_q     <= '0;
            dir_q   <= DIR_UP;
            tc_q    <= 1'b0;
            ge_q    <= 1'b1;
        end else begin
            ge_q <= ge_d;
            tc_q <= 1'b0;
            if (LD_VLD) begin
                q_q     <= LDATA;
                dir_q   <= UPDN;
                state_q <= RUN;
            end else if (state_q == RUN && CE) begin
                if (ONE && at_term) begin
                    state_q <= DONE;
                end else if (!sat_hold) begin
                    q_q  <= cnt_d;
                    tc_q <= cnt_hit;
                    if (ONE && cnt_hit)
                        state_q <= DONE;
                end
            end
        end
    end

    assign LD_RDY = !LSR && ((state_q != RUN) || !CE);
    assign Q      = q_q;
    assign TC     = tc_q;
    assign GE     = ge_q;
    assign BUSY   = (state_q == RUN);

endmodule

// File: tb/tb_ripple_cnt_ctl.sv
// Directed bench: free-running (ONESHOT=0) and one-shot instances share all inputs.
module tb_ripple_cnt_ctl;

    logic       CLK = 1'b0;
    logic       LSR, CE, LD_VLD, UPDN;
    logic [7:0] LDATA, CMPV;

    logic       w_rdy, w_tc, w_ge, w_busy;
    logic [7:0] w_q;
    logic       o_rdy, o_tc, o_ge, o_busy;
    logic [7:0] o_q;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ripple_cnt_ctl #(.WIDTH(8), .ONESHOT(0)) dut_w (
        .CLK(CLK), .LSR(LSR), .CE(CE), .LD_VLD(LD_VLD), .LD_RDY(w_rdy),
        .LDATA(LDATA), .UPDN(UPDN), .CMPV(CMPV),
        .Q(w_q), .TC(w_tc), .GE(w_ge), .BUSY(w_busy)
    );

    ripple_cnt_ctl #(.WIDTH(8), .ONESHOT(1)) dut_o (
        .CLK(CLK), .LSR(LSR), .CE(CE), .LD_VLD(LD_VLD), .LD_RDY(o_rdy),
        .LDATA(LDATA), .UPDN(UPDN), .CMPV(CMPV),
        .Q(o_q), .TC(o_tc), .GE(o_ge), .BUSY(o_busy)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    initial begin
        LSR = 1'b1; CE = 1'b0; LD_VLD = 1'b0; UPDN = 1'b0; LDATA = 8'h00; CMPV = 8'h00;
        #1;
        chk8("rst_q", w_q, 8'h00);
        chk1("rst_tc", w_tc, 1'b0);
        chk1("rst_ge", w_ge, 1'b1);
        chk1("rst_busy", w_busy, 1'b0);
        chk1("rst_rdy", w_rdy, 1'b0);
        tick();
        tick();
        LSR = 1'b0;
        #1;
        chk1("idle_rdy", w_rdy, 1'b1);
        chk1("idle_busy", w_busy, 1'b0);

        // Up count through terminal and wrap
        LDATA = 8'hFD; UPDN = 1'b1; LD_VLD = 1'b1; CE = 1'b1;
        tick();
        chk8("up_ld", w_q, 8'hFD);
        chk1("up_ld_busy", w_busy, 1'b1);
        chk1("up_ld_tc", w_tc, 1'b0);
        LD_VLD = 1'b0;
        tick();
        chk8("up_fe", w_q, 8'hFE);
        chk1("up_fe_tc", w_tc, 1'b0);
        tick();
        chk8("up_ff", w_q, 8'hFF);
        chk1("up_ff_tc", w_tc, 1'b1);
        chk1("os_up_tc", o_tc, 1'b1);
        chk1("os_up_busy", o_busy, 1'b0);
        tick();
        chk8("up_wrap", w_q, 8'h00);
        chk1("up_wrap_tc", w_tc, 1'b0);
        chk8("os_up_hold", o_q, 8'hFF);
        tick();
        chk8("up_01", w_q, 8'h01);
        chk1("up_01_tc", w_tc, 1'b0);

        // Load beats count in RUN
        LDATA = 8'h10; LD_VLD = 1'b1; CE = 1'b0;
        tick();
        chk8("ld10", w_q, 8'h10);
        LDATA = 8'h80; CE = 1'b1;
        #1;
        chk1("ldce_rdy", w_rdy, 1'b0);
        tick();
        chk8("ldce_q", w_q, 8'h80);
        LD_VLD = 1'b0;
        tick();
        chk8("ldce_cnt", w_q, 8'h81);
        CE = 1'b0;
        tick();
        chk8("ce0_hold", w_q, 8'h81);
        chk1("ce0_tc", w_tc, 1'b0);
        chk1("ce0_rdy", w_rdy, 1'b1);

        // GE lag against CMPV=0x40
        CMPV = 8'h40; LDATA = 8'h3E; LD_VLD = 1'b1;
        tick();
        LD_VLD = 1'b0;
        tick();
        chk8("ge_q3e", w_q, 8'h3E);
        chk1("ge_3e", w_ge, 1'b0);
        CE = 1'b1;
        tick();
        chk8("ge_q3f", w_q, 8'h3F);
        chk1("ge_3f", w_ge, 1'b0);
        tick();
        chk8("ge_q40", w_q, 8'h40);
        chk1("ge_40", w_ge, 1'b0);
        tick();
        chk8("ge_q41", w_q, 8'h41);
        chk1("ge_41", w_ge, 1'b1);
        CE = 1'b0; CMPV = 8'h50;
        tick();
        chk1("ge_cmpv50", w_ge, 1'b0);
        chk8("ge_hold", w_q, 8'h41);

        // One-shot count down to zero
        LDATA = 8'h02; UPDN = 1'b0; LD_VLD = 1'b1;
        tick();
        chk8("os_ld", o_q, 8'h02);
        chk1("os_ld_busy", o_busy, 1'b1);
        LD_VLD = 1'b0; CE = 1'b1;
        tick();
        chk8("os_1", o_q, 8'h01);
        chk1("os_1_tc", o_tc, 1'b0);
        tick();
        chk8("os_0", o_q, 8'h00);
        chk1("os_0_tc", o_tc, 1'b1);
        chk1("os_0_busy", o_busy, 1'b0);
        chk1("os_0_rdy", o_rdy, 1'b1);
        chk1("dn_0_tc", w_tc, 1'b1);
        tick();
        chk8("os_hold", o_q, 8'h00);
        chk1("os_hold_tc", o_tc, 1'b0);
        chk8("dn_wrap", w_q, 8'hFF);
        chk1("dn_wrap_tc", w_tc, 1'b0);
        tick();
        chk8("os_hold2", o_q, 8'h00);

        // Load equal to terminal value
        LDATA = 8'hFF; UPDN = 1'b1; LD_VLD = 1'b1; CE = 1'b0;
        tick();
        chk1("ldterm_tc", o_tc, 1'b0);
        chk1("ldterm_busy", o_busy, 1'b1);
        LD_VLD = 1'b0; CE = 1'b1;
        tick();
        chk8("ldterm_os_q", o_q, 8'hFF);
        chk1("ldterm_os_tc", o_tc, 1'b0);
        chk1("ldterm_os_busy", o_busy, 1'b0);
`ifdef RIPPLE_CNT_SAT_EN
        chk8("ldterm_w_q", w_q, 8'hFF);
`else
        chk8("ldterm_w_q", w_q, 8'h00);
`endif
        chk1("ldterm_w_tc", w_tc, 1'b0);

        // Arrival at TC_UP, then ten more enabled cycles
        LDATA = 8'hFE; LD_VLD = 1'b1; CE = 1'b0;
        tick();
        LD_VLD = 1'b0; CE = 1'b1;
        tick();
        chk8("sat_ff", w_q, 8'hFF);
        chk1("sat_ff_tc", w_tc, 1'b1);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] exp_q;
`ifdef RIPPLE_CNT_SAT_EN
            exp_q = 8'hFF;
`else
            exp_q = 8'(i);
`endif
            tick();
            chk8("sat_q", w_q, exp_q);
            chk1("sat_tc", w_tc, 1'b0);
        end

        // Async reset mid-count at Q=0x37
        LDATA = 8'h36; LD_VLD = 1'b1; CE = 1'b0;
        tick();
        LD_VLD = 1'b0; CE = 1'b1;
        tick();
        chk8("pre_rst_q", w_q, 8'h37);
        LSR = 1'b1;
        #1;
        chk8("lsr_q", w_q, 8'h00);
        chk1("lsr_tc", w_tc, 1'b0);
        chk1("lsr_busy", w_busy, 1'b0);
        chk1("lsr_rdy", w_rdy, 1'b0);
        chk1("lsr_ge", w_ge, 1'b1);
        LDATA = 8'hAA; LD_VLD = 1'b1;
        tick();
        chk8("lsr_drop", w_q, 8'h00);
        chk1("lsr_drop_busy", w_busy, 1'b0);
        LSR = 1'b0; LD_VLD = 1'b0;
        tick();
        chk8("post_q", w_q, 8'h00);
        chk1("post_busy", w_busy, 1'b0);
        chk1("post_rdy", w_rdy, 1'b1);
        chk8("post_os_q", o_q, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
